// File: rtl/hann_fft_ifft.sv
// hann_fft_ifft: frame-based Hann window + radix-2 FFT + IFFT reconstruction.
//
// Collects non-overlapping N-sample frames of real samples, applies a periodic
// Hann window, and runs LOG2N pipelined FFT stages followed by LOG2N IFFT
// stages. Each stage is N/2 parallel DIT butterflies with one register per
// stage. The result is scaled by 1/N and streamed out one element per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable_in    in_data valid this cycle
//   in_data      signed real input sample, Q(WIDTH-FRAC).FRAC
//   enable_out   ifft_out_re/im valid this cycle (N-cycle bursts)
//   ifft_out_re  signed real part of reconstructed sample
//   ifft_out_im  signed imaginary part of reconstructed sample

// One DIT butterfly: x = a + w*b, y = a - w*b. All values are fixed point.
// The inputs are two's-complement words.
module hann_fft_ifft_bfly #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic [WIDTH-1:0] i_a_re,
    input  logic [WIDTH-1:0] i_a_im,
    input  logic [WIDTH-1:0] i_b_re,
    input  logic [WIDTH-1:0] i_b_im,
    input  logic [WIDTH-1:0] i_w_re,
    input  logic [WIDTH-1:0] i_w_im,
    output logic [WIDTH-1:0] o_x_re,
    output logic [WIDTH-1:0] o_x_im,
    output logic [WIDTH-1:0] o_y_re,
    output logic [WIDTH-1:0] o_y_im
);
    // Full-width signed product, floor shift by FRAC, truncate to WIDTH.
    function automatic logic [WIDTH-1:0] f_mul(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        return WIDTH'(p >>> FRAC);
    endfunction

    logic [WIDTH-1:0] w_t_re;
    logic [WIDTH-1:0] w_t_im;

    assign w_t_re = f_mul(i_b_re, i_w_re) - f_mul(i_b_im, i_w_im);
    assign w_t_im = f_mul(i_b_re, i_w_im) + f_mul(i_b_im, i_w_re);
    assign o_x_re = i_a_re + w_t_re;
    assign o_x_im = i_a_im + w_t_im;
    assign o_y_re = i_a_re - w_t_re;
    assign o_y_im = i_a_im - w_t_im;
endmodule

module hann_fft_ifft #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int N     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] in_data,
    output logic             enable_out,
    output logic [WIDTH-1:0] ifft_out_re,
    output logic [WIDTH-1:0] ifft_out_im
);
    localparam int  LOG2N = $clog2(N);
    localparam int  S     = 2 * LOG2N;
    localparam real PI    = 3.14159265358979323846;

    // Elaboration-time sine via range reduction plus Taylor series. The
    // coefficient ROMs then depend only on plain constant arithmetic.
    function automatic real f_sin(input real a);
        real x, t, s;
        x = a;
        while (x > PI)  x = x - 2.0 * PI;
        while (x < -PI) x = x + 2.0 * PI;
        t = x;
        s = x;
        for (int i = 1; i < 20; i++) begin
            t = -t * x * x / ((2.0 * i) * (2.0 * i + 1.0));
            s = s + t;
        end
        return s;
    endfunction

    function automatic real f_cos(input real a);
        return f_sin(a + PI / 2.0);
    endfunction

    // Quantise a real value to QFRAC with round-half-away-from-zero.
    function automatic logic [WIDTH-1:0] f_q(input real x);
        real s;
        int  v;
        s = x;
        for (int i = 0; i < FRAC; i++) s = s * 2.0;
        if (s >= 0.0) v = $rtoi(s + 0.5);
        else          v = -$rtoi(0.5 - s);
        return WIDTH'(v);
    endfunction

    function automatic int f_brev(input int i);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++)
            if (i[b]) r = r | (1 << (LOG2N - 1 - b));
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] f_mul(input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        return WIDTH'(p >>> FRAC);
    endfunction

    // Capture: only N-1 samples are buffered. The N-th sample comes straight
    // from in_data on the edge that completes the frame.
    logic [N-2:0][WIDTH-1:0] r_buf;
    logic [LOG2N-1:0]        r_cnt;
    logic                    w_last;
    logic [N-1:0][WIDTH-1:0] w_xw;

    assign w_last = enable_in && (r_cnt == LOG2N'(N - 1));

    for (genvar k = 0; k < N; k++) begin : g_win
        localparam logic [WIDTH-1:0] WK = f_q(0.5 * (1.0 - f_cos(2.0 * PI * k / N)));
        if (k == N - 1) begin : g_live
            assign w_xw[k] = f_mul(in_data, WK);
        end else begin : g_buf
            assign w_xw[k] = f_mul(r_buf[k], WK);
        end
    end

    // Stage 0 holds the windowed frame (real only, natural order). Stages
    // 1..LOG2N are the FFT, and stages LOG2N+1..S are the IFFT.
    logic [N-1:0][WIDTH-1:0] r_re [0:S];
    logic [N-1:0][WIDTH-1:0] r_im [1:S];
    logic [S:0]              r_vld_pipe;
    logic [N-1:0][WIDTH-1:0] w_in_re [1:S];
    logic [N-1:0][WIDTH-1:0] w_in_im [1:S];
    logic [N-1:0][WIDTH-1:0] w_bo_re [1:S];
    logic [N-1:0][WIDTH-1:0] w_bo_im [1:S];

    for (genvar s = 1; s <= S; s++) begin : g_stg
        localparam int LS   = (s <= LOG2N) ? s : s - LOG2N;
        localparam bit INV  = (s > LOG2N);
        localparam int HALF = 1 << (LS - 1);

        // The first stage of each transform reads its input in bit-reversed order.
        for (genvar i = 0; i < N; i++) begin : g_in
            localparam int SRC = (LS == 1) ? f_brev(i) : i;
            if (s == 1) begin : g_first
                assign w_in_re[s][i] = r_re[0][SRC];
                assign w_in_im[s][i] = '0;
            end else begin : g_next
                assign w_in_re[s][i] = r_re[s-1][SRC];
                assign w_in_im[s][i] = r_im[s-1][SRC];
            end
        end

        for (genvar p = 0; p < N / 2; p++) begin : g_bf
            localparam int  J   = p % HALF;
            localparam int  TOP = ((p >> (LS - 1)) << LS) + J;
            localparam int  BOT = TOP + HALF;
            localparam int  TW  = J << (LOG2N - LS);
            localparam real ANG = 2.0 * PI * TW / N;
            localparam logic [WIDTH-1:0] TWR = f_q(f_cos(ANG));
            localparam logic [WIDTH-1:0] TWI = INV ? f_q(f_sin(ANG)) : f_q(-f_sin(ANG));

            hann_fft_ifft_bfly #(.WIDTH(WIDTH), .FRAC(FRAC)) u_bf (
                .i_a_re (w_in_re[s][TOP]),
                .i_a_im (w_in_im[s][TOP]),
                .i_b_re (w_in_re[s][BOT]),
                .i_b_im (w_in_im[s][BOT]),
                .i_w_re (TWR),
                .i_w_im (TWI),
                .o_x_re (w_bo_re[s][TOP]),
                .o_x_im (w_bo_im[s][TOP]),
                .o_y_re (w_bo_re[s][BOT]),
                .o_y_im (w_bo_im[s][BOT])
            );
        end
    end

    // The 1/N IFFT normalisation is an arithmetic shift of the last stage.
    logic [N-1:0][WIDTH-1:0] w_scl_re;
    logic [N-1:0][WIDTH-1:0] w_scl_im;

    for (genvar k = 0; k < N; k++) begin : g_scl
        assign w_scl_re[k] = $signed(r_re[S][k]) >>> LOG2N;
        assign w_scl_im[k] = $signed(r_im[S][k]) >>> LOG2N;
    end

    // Output bank: element 0 goes straight to the output register on the load
    // edge. Elements 1..N-1 wait in a shift register that drains one per cycle.
    logic [N-2:0][WIDTH-1:0] r_sh_re;
    logic [N-2:0][WIDTH-1:0] r_sh_im;
    logic [LOG2N-1:0]        r_ocnt;
    logic                    r_oen;
    logic [WIDTH-1:0]        r_ore;
    logic [WIDTH-1:0]        r_oim;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_vld_pipe <= '0;
            r_oen      <= 1'b0;
            r_ore      <= '0;
            r_oim      <= '0;
            r_ocnt     <= '0;
        end else begin
            if (enable_in) r_cnt <= r_cnt + LOG2N'(1);
            r_vld_pipe <= {r_vld_pipe[S-1:0], w_last};
            if (r_vld_pipe[S]) begin
                // A new frame pre-empts nothing: back-to-back frames
                // arrive exactly N cycles apart, which is when the previous
                // burst finishes.
                r_oen  <= 1'b1;
                r_ore  <= w_scl_re[0];
                r_oim  <= w_scl_im[0];
                r_ocnt <= LOG2N'(1);
            end else if (r_oen) begin
                if (r_ocnt == '0) begin
                    r_oen <= 1'b0;
                end else begin
                    r_ore  <= r_sh_re[0];
                    r_oim  <= r_sh_im[0];
                    r_ocnt <= r_ocnt + LOG2N'(1);
                end
            end
        end
    end

    // Datapath registers. These need no reset because validity is
    // tracked separately.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N - 1; k++)
            if (enable_in && (r_cnt == LOG2N'(k))) r_buf[k] <= in_data;
        if (w_last) r_re[0] <= w_xw;
        for (int s = 1; s <= S; s++) begin
            r_re[s] <= w_bo_re[s];
            r_im[s] <= w_bo_im[s];
        end
        if (r_vld_pipe[S]) begin
            for (int k = 0; k < N - 1; k++) begin
                r_sh_re[k] <= w_scl_re[k+1];
                r_sh_im[k] <= w_scl_im[k+1];
            end
        end else if (r_oen) begin
            for (int k = 0; k < N - 2; k++) begin
                r_sh_re[k] <= r_sh_re[k+1];
                r_sh_im[k] <= r_sh_im[k+1];
            end
        end
    end

    assign enable_out  = r_oen;
    assign ifft_out_re = r_ore;
    assign ifft_out_im = r_oim;
endmodule

// File: tb/tb_hann_fft_ifft.sv
// Testbench for hann_fft_ifft (N=16, FRAC=24). Expected outputs are the
// ideal w[n]*x[n] computed in real arithmetic. A scoreboard queue is filled
// as frames are driven and emptied by an output monitor.
module tb_hann_fft_ifft;
    localparam int  N  = 16;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_in = 1'b0;
    logic [31:0] in_data = '0;
    logic        enable_out;
    logic [31:0] ifft_out_re;
    logic [31:0] ifft_out_im;

    hann_fft_ifft #(.WIDTH(32), .FRAC(24), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_in   (enable_in),
        .in_data     (in_data),
        .enable_out  (enable_out),
        .ifft_out_re (ifft_out_re),
        .ifft_out_im (ifft_out_im)
    );

    always #5 clk = ~clk;

    typedef struct { int re; int im; } exp_t;
    typedef struct { int x[N]; int er[N]; } vec_t;

    exp_t sb[$];
    int   cap_re[$];
    int   cap_im[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   run     = 0;
    int   max_run = 0;

    function automatic int gold(input int x, input int n);
        real w, v;
        w = 0.5 * (1.0 - $cos(2.0 * PI * n / N));
        v = x * w;
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        int d;
        d = act - exp;
        n_tests++;
        if (d < -tol || d > tol) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    // Output monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (enable_out === 1'b1) begin
                n_out++;
                run++;
                if (run > max_run) max_run = run;
                cap_re.push_back(int'($signed(ifft_out_re)));
                cap_im.push_back(int'($signed(ifft_out_im)));
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual enable_out=1 required 0 (nothing pending)");
                end else begin
                    e = sb.pop_front();
                    chk("out_re", int'($signed(ifft_out_re)), e.re, 64);
                    chk("out_im", int'($signed(ifft_out_im)), e.im, 64);
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic send(input vec_t v, input bit gaps);
        exp_t e;
        for (int n = 0; n < N; n++) begin
            e.re = v.er[n];
            e.im = 0;
            sb.push_back(e);
            @(posedge clk); #1;
            enable_in = 1'b1;
            in_data   = v.x[n];
            if (gaps) begin
                @(posedge clk); #1;
                enable_in = 1'b0;
                in_data   = $urandom();
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        enable_in = 1'b0;
        in_data   = $urandom();
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((sb.size() != 0 || enable_out) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk(nm, sb.size(), 0, 0);
    endtask

    task automatic chk_zero_out(input string nm);
        chk({nm, "_en"}, int'(enable_out), 0, 0);
        chk({nm, "_re"}, int'($signed(ifft_out_re)), 0, 0);
        chk({nm, "_im"}, int'($signed(ifft_out_im)), 0, 0);
    endtask

    initial begin
        vec_t tbl[6];
        int   ref_re[$];
        int   ref_im[$];
        int   len;
        int   base;

        for (int i = 0; i < N; i++) begin
            tbl[0].x[i] = 32'h0100_0000;
            tbl[1].x[i] = (i == 8) ? 32'h0100_0000 : 0;
            tbl[2].x[i] = (i - 8) * 32'h0008_0000;
            tbl[3].x[i] = (i % 2 == 1) ? -32'sh0040_0000 : 32'sh0040_0000;
            tbl[4].x[i] = int'($urandom_range(0, 32'h0100_0000)) - 32'sh0080_0000;
            tbl[5].x[i] = int'($urandom_range(0, 32'h0100_0000)) - 32'sh0080_0000;
        end
        for (int t = 0; t < 6; t++)
            for (int i = 0; i < N; i++) tbl[t].er[i] = gold(tbl[t].x[i], i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero_out("reset");
        reset = 1'b0;

        // All table vectors back-to-back with enable_in held high
        for (int t = 0; t < 6; t++) send(tbl[t], 1'b0);
        idle();
        drain("drain_table");

        // Latency and burst length: the last sample is taken at edge t
        send(tbl[2], 1'b0);
        @(posedge clk); #1;
        enable_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("lat_before_t9", int'(enable_out), 0, 0);
        @(posedge clk); #1;
        chk("lat_after_t9", int'(enable_out), 1, 0);
        len = 0;
        while (enable_out && len < 40) begin
            len++;
            @(posedge clk); #1;
        end
        chk("burst_len", len, 16, 0);
        drain("drain_lat");

        // Two back-to-back frames give 32 contiguous outputs
        base    = n_out;
        max_run = 0;
        send(tbl[4], 1'b0);
        send(tbl[5], 1'b0);
        idle();
        drain("drain_b2b");
        chk("b2b_count", n_out - base, 32, 0);
        chk("b2b_contig", max_run, 32, 0);

        // Gaps on enable_in give identical outputs to the gapless case
        cap_re.delete();
        cap_im.delete();
        send(tbl[4], 1'b0);
        idle();
        drain("drain_nogap");
        ref_re = cap_re;
        ref_im = cap_im;
        cap_re.delete();
        cap_im.delete();
        send(tbl[4], 1'b1);
        idle();
        drain("drain_gap");
        chk("gap_count", cap_re.size(), ref_re.size(), 0);
        for (int i = 0; i < N; i++) begin
            if (i < cap_re.size() && i < ref_re.size()) begin
                chk("gap_re_same", cap_re[i], ref_re[i], 0);
                chk("gap_im_same", cap_im[i], ref_im[i], 0);
            end
        end

        // A partial frame produces nothing
        base = n_out;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            enable_in = 1'b1;
            in_data   = tbl[3].x[i];
        end
        idle();
        repeat (30) @(posedge clk);
        #1;
        chk("partial_no_out", n_out - base, 0, 0);

        // A mid-frame reset discards the partial frame
        reset = 1'b1;
        @(posedge clk); #1;
        chk_zero_out("mid_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk_zero_out("post_reset");
        base = n_out;
        send(tbl[0], 1'b0);
        idle();
        drain("drain_reset");
        chk("reset_burst_count", n_out - base, 16, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "timeout");
    end
endmodule
